// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial addition controller that feeds an external
// 1-bit full adder one operand bit pair per clock, LSB first. The adder's
// carry is registered here and fed back on the next cycle. The serial sum
// bits and the final carry are assembled into a parallel result, and a
// one-cycle done pulse marks when that result is valid.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_carry
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] sum_sr_q;
  logic [WIDTH-1:0] sum_sr_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             c_out_q;
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    cnt_q;

  // The returning sum bit enters at the MSB, so after WIDTH shifts the
  // first (LSB) result bit has reached bit 0.
  always_comb begin
    sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
  end

  // Controller FSM: operand capture, shifting, carry loop and result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      c_out_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples
      // pre-edge values and the order of statements below does not matter.
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sr_q   <= a;
            b_sr_q   <= b;
            carry_q  <= c_in;
            cnt_q    <= '0;
            sum_sr_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          sum_sr_q <= sum_sr_d;
          carry_q  <= fa_carry;
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            sum_q   <= sum_sr_d;
            c_out_q <= fa_carry;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          // A start seen here is dropped; a launch needs an IDLE cycle.
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // busy_q is high exactly in SHIFT, so it gates the adder drive to zero in
  // IDLE and DONE. These depend only on registers: no loop through the adder.
  assign fa_a   = busy_q & a_sr_q[0];
  assign fa_b   = busy_q & b_sr_q[0];
  assign fa_cin = busy_q & carry_q;

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl: models the external full adder, applies a
// table of hand-computed additions, then runs multi-cycle corner sequences
// (held start, asynchronous reset mid-operation) and a random sweep.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_carry;

  int n_vec = 0;
  int n_err = 0;
  logic last_k2_cin;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .fa_a     (fa_a),
    .fa_b     (fa_b),
    .fa_cin   (fa_cin),
    .fa_sum   (fa_sum),
    .fa_carry (fa_carry)
  );

  // External 1-bit full adder (fa_v1).
  assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
  assign fa_carry = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic             vc;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic run_op(input string name, input logic [WIDTH-1:0] ta,
                        input logic [WIDTH-1:0] tb_v, input logic tc,
                        output logic [WIDTH-1:0] rs, output logic rc);
    int   busy_n;
    int   done_n;
    int   done_k;
    logic fa_bad;
    busy_n = 0;
    done_n = 0;
    done_k = 0;
    fa_bad = 1'b0;
    rs     = 'x;
    rc     = 1'bx;
    a      = ta;
    b      = tb_v;
    c_in   = tc;
    start  = 1'b1;
    @(negedge clk);
    // Operands are now captured; scramble them to prove they are held.
    start = 1'b0;
    a     = ~ta;
    b     = ~tb_v;
    c_in  = ~tc;
    for (int k = 1; k <= WIDTH + 3; k++) begin
      if (k == 1) check({name, " fa_first"}, {29'd0, fa_a, fa_b, fa_cin}, {29'd0, ta[0], tb_v[0], tc});
      if (k == 2) last_k2_cin = fa_cin;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_k = k;
        rs     = sum;
        rc     = c_out;
      end
      if (!busy && ({fa_a, fa_b, fa_cin} != 3'b000)) fa_bad = 1'b1;
      if (k < WIDTH + 3) @(negedge clk);
    end
    check({name, " busy_cycles"}, busy_n, WIDTH);
    check({name, " done_count"}, done_n, 1);
    check({name, " done_latency"}, done_k, WIDTH + 1);
    check({name, " fa_idle_zero"}, {31'd0, fa_bad}, 0);
    check({name, " sum_hold"}, {24'd0, sum}, {24'd0, rs});
  endtask

  initial begin
    logic [WIDTH-1:0] rs;
    logic             rc;
    logic [WIDTH:0]   e;
    logic [WIDTH:0]   exp_q[$];
    int               accepts;
    int               dones;

    vecs[0] = '{8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[8] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[9] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
    #2;
    check("reset_outputs", {20'd0, busy, done, sum, c_out, fa_a, fa_b, fa_cin}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vc, rs, rc);
      check($sformatf("vec%0d sum", i), {24'd0, rs}, {24'd0, vecs[i].exp_sum});
      check($sformatf("vec%0d c_out", i), {31'd0, rc}, {31'd0, vecs[i].exp_cout});
    end

    // Carry propagates into the second SHIFT cycle for FF+01.
    run_op("carry_loop", 8'hFF, 8'h01, 1'b0, rs, rc);
    check("carry_loop k2_cin", {31'd0, last_k2_cin}, 1);

    // start held high: one done per IDLE visit, operands changing every cycle.
    accepts = 0;
    dones   = 0;
    for (int cyc = 0; cyc < 45 + WIDTH + 3; cyc++) begin
      if (done) begin
        dones++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("held_start result", {23'd0, c_out, sum}, {23'd0, e});
        end else begin
          check("held_start unexpected_done", 1, 0);
        end
      end
      start = (cyc < 45);
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      c_in  = 1'($urandom);
      if (start && !busy && !done) begin
        exp_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in});
        accepts++;
      end
      @(negedge clk);
    end
    check("held_start done_count", dones, accepts);
    check("held_start accepts", {31'd0, accepts >= 4}, 1);

    // Asynchronous reset mid-operation after three SHIFT edges.
    a     = 8'h0F;
    b     = 8'h01;
    c_in  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset outputs", {20'd0, busy, done, sum, c_out, fa_a, fa_b, fa_cin}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_reset", 8'h10, 8'h20, 1'b0, rs, rc);
    check("after_reset sum", {24'd0, rs}, 32'h30);
    check("after_reset c_out", {31'd0, rc}, 0);

    // Random sweep against a+b+c_in.
    for (int i = 0; i < 200; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rci;
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      rci = 1'($urandom);
      e   = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rci};
      run_op($sformatf("rand%0d", i), ra, rb, rci, rs, rc);
      check($sformatf("rand%0d result", i), {23'd0, rc, rs}, {23'd0, e});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
